oddeven_sort_hs: RTL and testbench



---
 rtl/oddeven_sort_hs.sv | 109 ++++++++++
 tb/tb_oddeven_sort_hs.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/oddeven_sort_hs.sv
// Streaming odd-even transposition sorter: one compare-exchange phase per clock,
// valid/ready on both sides. Define ODDEVEN_SORT_EARLY_EXIT_EN to stop after two swap-free phases.
module oddeven_sort_hs #(
    parameter int N = 16,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W*N-1:0] data_in,
    input  logic         descend,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W*N-1:0] data_out,
    output logic         busy
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            desc_q;
    logic [W*N-1:0]  work_q, work_d;
    logic            out_valid_q, busy_q;
    logic            swapped;
    logic            last_phase;
    logic            stop;
    logic            accept;

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign data_out = work_q;
    assign out_valid = out_valid_q;
    assign busy     = busy_q;

    // Even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..; pairs never overlap.
    always_comb begin
        work_d  = work_q;
        swapped = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (cnt_q[0] == 1'(i % 2)) begin
                if ((work_q[i*W +: W] != work_q[(i+1)*W +: W]) &&
                    ((work_q[i*W +: W] > work_q[(i+1)*W +: W]) ^ desc_q)) begin
                    work_d[i*W +: W]     = work_q[(i+1)*W +: W];
                    work_d[(i+1)*W +: W] = work_q[i*W +: W];
                    swapped              = 1'b1;
                end
            end
        end
    end

    assign last_phase = (cnt_q == CW'(N - 1));

`ifdef ODDEVEN_SORT_EARLY_EXIT_EN
    logic prev_swap_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            prev_swap_q <= 1'b1;
        else if (accept)
            prev_swap_q <= 1'b1;
        else if (state_q == SORT)
            prev_swap_q <= swapped;
    end

    assign stop = last_phase || ((cnt_q != '0) && !swapped && !prev_swap_q);
`else
    assign stop = last_phase;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            desc_q      <= 1'b0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            state_q     <= SORT;
            cnt_q       <= '0;
            desc_q      <= descend;
            work_q      <= data_in;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                SORT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (stop) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_oddeven_sort_hs.sv
// Directed bench for oddeven_sort_hs: N=16/W=8 instance plus an N=5/W=12 instance.
module tb_oddeven_sort_hs;
    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    // N=16, W=8 instance
    logic         a_in_valid, a_in_ready, a_desc, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_data_in, a_data_out;

    oddeven_sort_hs #(.N(16), .W(8)) dut_a (
        .clk(clk), .rstb(rstb), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data_in(a_data_in), .descend(a_desc), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .data_out(a_data_out), .busy(a_busy));

    // N=5, W=12 instance
    logic        b_in_valid, b_in_ready, b_desc, b_out_valid, b_out_ready, b_busy;
    logic [59:0] b_data_in, b_data_out;

    oddeven_sort_hs #(.N(5), .W(12)) dut_b (
        .clk(clk), .rstb(rstb), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_in(b_data_in), .descend(b_desc), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .data_out(b_data_out), .busy(b_busy));

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] VEC1     = 128'hAB154354_0518EF00_FABC6358_12339915;
    localparam logic [127:0] VEC1_ASC = 128'hFAEFBCAB_99635854_43331815_15120500;
    localparam logic [127:0] VEC1_DSC = 128'h00051215_15183343_54586399_ABBCEFFA;
    localparam logic [127:0] SORTED   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [59:0]  VB       = 60'h001_7FF_800_000_FFF;
    localparam logic [59:0]  VB_ASC   = 60'hFFF_800_7FF_001_000;
`ifdef ODDEVEN_SORT_EARLY_EXIT_EN
    localparam int LAT_FULL   = 0;  // data dependent, not checked
    localparam int LAT_SORTED = 2;
    localparam int LAT_B      = 0;
`else
    localparam int LAT_FULL   = 16;
    localparam int LAT_SORTED = 16;
    localparam int LAT_B      = 5;
`endif

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic send_a(input logic [127:0] d, input logic desc);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_data_in  = d;
        a_desc     = desc;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_data_in  = '1;
        a_desc     = ~desc;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) chk("a_timeout", 128'(lat), 128'(0));
    endtask

    task automatic release_a(input string tag);
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk({tag, "_drop"}, 128'(a_out_valid), 128'(0));
    endtask

    task automatic sort_a(input string tag, input logic [127:0] d, input logic desc,
                          input logic [127:0] exp, input int exp_lat);
        int lat;
        send_a(d, desc);
        wait_a(lat);
        if (exp_lat > 0) chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_data"}, a_data_out, exp);
        chk({tag, "_busy"}, 128'(a_busy), 128'(0));
        release_a(tag);
    endtask

    initial begin
        int lat;
        rstb = 1'b0;
        a_in_valid = 0; a_data_in = '0; a_desc = 0; a_out_ready = 0;
        b_in_valid = 0; b_data_in = '0; b_desc = 0; b_out_ready = 0;
        #3;
        chk("rst_valid", 128'(a_out_valid), 128'(0));
        chk("rst_busy",  128'(a_busy),      128'(0));
        chk("rst_data",  a_data_out,        128'(0));
        chk("rst_ready", 128'(a_in_ready),  128'(1));
        @(negedge clk);
        rstb = 1'b1;

        sort_a("asc",  VEC1, 1'b0, VEC1_ASC, LAT_FULL);
        sort_a("desc", VEC1, 1'b1, VEC1_DSC, LAT_FULL);
        sort_a("presorted", SORTED, 1'b0, SORTED, LAT_SORTED);

        // backpressure, then handoff with a new vector on the same edge
        send_a(VEC1, 1'b0);
        wait_a(lat);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_data",  a_data_out,       VEC1_ASC);
            chk("bp_ready", 128'(a_in_ready), 128'(0));
            chk("bp_valid", 128'(a_out_valid), 128'(1));
        end
        @(negedge clk);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_data_in   = SORTED;
        a_desc      = 1'b0;
        #1;
        chk("ho_ready", 128'(a_in_ready), 128'(1));
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        a_data_in   = '1;
        chk("ho_valid", 128'(a_out_valid), 128'(0));
        chk("ho_busy",  128'(a_busy),      128'(1));
        wait_a(lat);
        if (LAT_SORTED > 0) chk("ho_lat", 128'(lat), 128'(LAT_SORTED));
        chk("ho_data", a_data_out, SORTED);
        release_a("ho");

        // asynchronous reset in the middle of a sort
        send_a(VEC1, 1'b0);
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 128'(a_busy), 128'(LAT_FULL > 0 ? 1 : a_busy));
        #2 rstb = 1'b0;
        #1;
        chk("ar_valid", 128'(a_out_valid), 128'(0));
        chk("ar_data",  a_data_out,        128'(0));
        chk("ar_busy",  128'(a_busy),      128'(0));
        chk("ar_ready", 128'(a_in_ready),  128'(1));
        @(negedge clk);
        rstb = 1'b1;
        sort_a("post_rst", VEC1, 1'b1, VEC1_DSC, LAT_FULL);

        // N=5, W=12 odd-length vector
        @(negedge clk);
        b_in_valid = 1'b1;
        b_data_in  = VB;
        b_desc     = 1'b0;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_data_in  = '1;
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (LAT_B > 0) chk("n5_lat", 128'(lat), 128'(LAT_B));
        chk("n5_data", 128'(b_data_out), 128'(VB_ASC));
        chk("n5_ready", 128'(b_in_ready), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
